// File: rtl/reg_file24_pkg.sv
// cpu24_pkg: constants and types shared by the 24-bit datapath blocks.
//   DATA_W / ADDR_W / NREGS   : operand width, register address width, register count
//   FLAG_Z / FLAG_V / FLAG_C  : bit positions inside the 3-bit flag register
//   word_t / reg_addr_t       : operand and register-address types
//   wr_commit()               : true when a write actually lands in storage
package cpu24_pkg;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 1 << ADDR_W;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    // R0 is hardwired to zero, so a write aimed at it never commits.
    function automatic logic wr_commit(input logic we, input reg_addr_t waddr);
        return we && (waddr != '0);
    endfunction

endpackage

// File: rtl/reg_file24_if.sv
// reg_file24_if: pipeline-side bus of the register file.
//   master : pipeline (drives read/write addresses, write data, flag inputs)
//   slave  : register file (drives read data, flags, write counter)
interface reg_file24_if;
    import cpu24_pkg::*;

    reg_addr_t   RAddrA;
    reg_addr_t   RAddrB;
    word_t       RDataA;
    word_t       RDataB;
    logic        WE;
    reg_addr_t   WAddr;
    word_t       WData;
    logic        FlagWE;
    logic        ZeroIn;
    logic        OverflowIn;
    logic        CarryIn;
    logic [2:0]  Flags;
    logic [7:0]  WriteCount;

    modport master (
        output RAddrA, RAddrB, WE, WAddr, WData, FlagWE, ZeroIn, OverflowIn, CarryIn,
        input  RDataA, RDataB, Flags, WriteCount
    );

    modport slave (
        input  RAddrA, RAddrB, WE, WAddr, WData, FlagWE, ZeroIn, OverflowIn, CarryIn,
        output RDataA, RDataB, Flags, WriteCount
    );

endinterface

// File: rtl/reg_file24_rf_read_port.sv
// rf_read_port: one combinational read port of the register file.
//   regs  : flattened storage array from the top
//   raddr : read address
//   we/waddr/wdata : current-cycle write, used for write-through bypass
//   rdata : operand out (R0 reads zero, bypassed write data wins over storage)
module rf_read_port
    import cpu24_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int NR = NREGS
) (
    input  logic [NR-1:0][DW-1:0] regs,
    input  reg_addr_t             raddr,
    input  logic                  we,
    input  reg_addr_t             waddr,
    input  logic [DW-1:0]         wdata,
    output logic [DW-1:0]         rdata
);

    always_comb begin
        rdata = '0;
        if (raddr == '0)
            rdata = '0;
        else if (wr_commit(we, waddr) && (waddr == raddr))
            rdata = wdata;      // value being written this cycle, not the stale one
        else
            rdata = regs[raddr];
    end

endmodule

// File: rtl/reg_file24.sv
// reg_file24: 16 x 24-bit register file with flag register, feeding the ALU.
//   Clock : rising-edge system clock
//   Reset : synchronous, active-high; clears registers, flags and WriteCount
//   bus   : reg_file24_if.slave
//           RAddrA/RAddrB -> RDataA/RDataB (combinational, with write bypass)
//           WE/WAddr/WData  (registered write, R0 ignored)
//           FlagWE/ZeroIn/OverflowIn/CarryIn -> Flags {Z,V,C}
//           WriteCount      (saturating count of committed writes)
module reg_file24
    import cpu24_pkg::*;
#(
    parameter int DATA_W = cpu24_pkg::DATA_W,
    parameter int ADDR_W = cpu24_pkg::ADDR_W,
    parameter int NREGS  = 1 << ADDR_W
) (
    input  logic         Clock,
    input  logic         Reset,
    reg_file24_if.slave  bus
);

    localparam int NPORTS = 2;

    logic [NREGS-1:0][DATA_W-1:0]  regs;
    logic [2:0]                    flags;
    logic [7:0]                    wcnt;
    logic                          commit;

    reg_addr_t [NPORTS-1:0]        raddr;
    logic [NPORTS-1:0][DATA_W-1:0] rdata;

    assign commit = wr_commit(bus.WE, bus.WAddr);

    // Storage, flags and counter. Reset overrides any write issued in the same cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            regs  <= '0;
            flags <= '0;
            wcnt  <= '0;
        end else begin
            if (commit)
                regs[bus.WAddr] <= bus.WData;
            if (bus.FlagWE) begin
                flags[FLAG_Z] <= bus.ZeroIn;
                flags[FLAG_V] <= bus.OverflowIn;
                flags[FLAG_C] <= bus.CarryIn;
            end
            if (commit && (wcnt != 8'hFF))
                wcnt <= wcnt + 8'd1;
        end
    end

    assign raddr = {bus.RAddrB, bus.RAddrA};

    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
        rf_read_port #(.DW(DATA_W), .NR(NREGS)) u_rd (
            .regs  (regs),
            .raddr (raddr[p]),
            .we    (bus.WE),
            .waddr (bus.WAddr),
            .wdata (bus.WData),
            .rdata (rdata[p])
        );
    end

    assign bus.RDataA     = rdata[0];
    assign bus.RDataB     = rdata[1];
    assign bus.Flags      = flags;
    assign bus.WriteCount = wcnt;

endmodule

// File: doc/reg_file24.md
Name: reg_file24

Overview:
- 24-bit register file plus status-flag register; sits directly upstream of the 24-bit ALU.
- Two asynchronous read ports drive the ALU A and B operands. One synchronous write port takes the writeback Result.
- A 3-bit flag register latches the ALU's Zero, Overflow and CarryOut for later branch evaluation.

Parameters:
- DATA_W, 24, register and operand width
- ADDR_W, 4, register address width
- NREGS, 16, number of architectural registers (2**ADDR_W); R0 hardwired to zero

Ports:
- Clock  input  1  single system clock, rising-edge
- Reset  input  1  synchronous, active-high; clears all registers and flags
- RAddrA  input  ADDR_W  read address, port A
- RAddrB  input  ADDR_W  read address, port B
- RDataA  output  DATA_W  operand to ALU A
- RDataB  output  DATA_W  operand to ALU B
- WE  input  1  register write enable
- WAddr  input  ADDR_W  write address
- WData  input  DATA_W  write data (ALU Result / writeback)
- FlagWE  input  1  flag register update enable
- ZeroIn  input  1  ALU Zero
- OverflowIn  input  1  ALU Overflow
- CarryIn  input  1  ALU CarryOut
- Flags  output  3  registered {Z, V, C}
- WriteCount  output  8  saturating count of committed writes (debug/perf)

Behaviour:
- All state updates on the rising edge of Clock. There is no asynchronous path into state.
- Reset (synchronous, active-high):
  - Next edge: all NREGS registers = 0, Flags = 3'b000, WriteCount = 0.
  - WE/FlagWE asserted in the same cycle as Reset are ignored; Reset wins.
  - Reset asserted mid-sequence discards any in-flight write.
- Reads (combinational, zero latency): RDataX = reg[RAddrX].
  - Address 0 always returns 24'h000000.
- Write (1-cycle latency): WE=1 and WAddr!=0 at edge → reg[WAddr] <= WData.
  - WE=1 with WAddr=0: no state change, WriteCount not incremented.
- Write-through bypass:
  - If WE=1, WAddr!=0 and RAddrX==WAddr in the same cycle, RDataX = WData (new value), not the stored value.
  - Applies independently to A and B. Both ports may bypass simultaneously.
- Flags (1-cycle latency): FlagWE=1 → Flags <= {ZeroIn, OverflowIn, CarryIn}; otherwise hold.
  - Flags are independent of WE; both may update in the same cycle.
- WriteCount: increments by 1 per committed write (WE=1, WAddr!=0, Reset=0). Saturates at 8'hFF; no wrap.
- Back-to-back writes to the same address: the last edge wins. No stall, no hazard signalling; forwarding beyond the bypass is the pipeline's responsibility.
- Reset values: RDataA/RDataB = 0 for all addresses after reset; Flags = 0; WriteCount = 0.
- No X propagation: the storage array is fully reset; unknown addresses are not possible (NREGS = 2**ADDR_W).

Decomposition:
- Shared package cpu24_pkg:
  - DATA_W = 24 and ADDR_W = 4 constants.
  - Flag bit indices FLAG_Z = 2, FLAG_V = 1, FLAG_C = 0.
  - typedefs word_t (24-bit) and reg_addr_t (4-bit).
- One natural sub-module: rf_read_port (address decode + R0 zeroing + bypass mux), instantiated twice for ports A and B.
- Storage array, flag register and counter stay in the top module.

Test Plan:
- Reset then read all 16 addresses → RDataA = RDataB = 24'h000000, Flags = 0, WriteCount = 0.
- WE=1, WAddr=5, WData=24'hABCDEF; next cycle RAddrA=5, RAddrB=0 → RDataA = 24'hABCDEF, RDataB = 0, WriteCount = 1.
- Same cycle WE=1, WAddr=7, WData=24'h123456 with RAddrA=RAddrB=7 → both outputs show 24'h123456 before the edge; stored value persists after WE drops.
- WE=1, WAddr=0, WData=24'hFFFFFF → RDataA at address 0 stays 0; WriteCount unchanged.
- FlagWE=1 with Zero=1, Overflow=0, Carry=1 → Flags = 3'b101 next cycle. FlagWE=0 with inputs changed → Flags hold 3'b101.
- Reset=1 together with WE=1, WAddr=3, WData=24'h000001 → reg3 = 0. Then 300 valid writes → WriteCount = 8'hFF, no wrap.
